recompute_scheduler: RTL

Parametrised fault-to-recompute-unit scheduler for the BISR recompute-unit path. It serially scans the self-test pass/fail matrix of a ROWS×COLS systolic array and allocates up to NUM_RU faulty PEs to recompute units. It then runs repeatable column sweeps that drive each recompute unit's data/weight coordinates. It sits between the STW test block and the recompute-unit datapath, replacing the fixed, free-running controller with a start/stall-controlled, overflow-aware scheduler.

---
 rtl/recompute_scheduler.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/recompute_scheduler.sv
// Fault-to-recompute-unit scheduler: serially scans the PE pass/fail matrix into a
// fault table, then drives per-RU coordinates during stall-controlled column sweeps.
module recompute_scheduler #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int NUM_RU = 4,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int FW = $clog2(NUM_RU + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ROWS*COLS-1:0]   stw_result,
  input  logic                   scan_start,
  input  logic                   recompute_req,
  input  logic                   stall,
  output logic                   busy,
  output logic                   scan_done,
  output logic                   sweep_done,
  output logic                   overflow,
  output logic [FW-1:0]          fault_count,
  output logic [NUM_RU-1:0]      ru_valid,
  output logic [NUM_RU*RW-1:0]   data_row,
  output logic [NUM_RU*CW-1:0]   data_col,
  output logic [NUM_RU*RW-1:0]   weight_row,
  output logic [NUM_RU*CW-1:0]   weight_col
);

  localparam int IW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, ARMED, SWEEP} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [RW-1:0]   scan_r;
  logic [CW-1:0]   scan_c;
  logic [CW-1:0]   k;
  logic [RW-1:0]   tab_row [NUM_RU];
  logic [CW-1:0]   tab_col [NUM_RU];
  logic [NUM_RU-1:0] tab_vld;
  logic            pe_pass;
  logic            go_scan;

  assign pe_pass = stw_result[idx];
  assign go_scan = scan_start && (state == IDLE || state == ARMED);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      scan_r      <= '0;
      scan_c      <= '0;
      k           <= '0;
      busy        <= 1'b0;
      scan_done   <= 1'b0;
      sweep_done  <= 1'b0;
      overflow    <= 1'b0;
      fault_count <= '0;
      tab_vld     <= '0;
      ru_valid    <= '0;
      data_row    <= '0;
      data_col    <= '0;
      weight_row  <= '0;
      weight_col  <= '0;
      for (int unsigned n = 0; n < NUM_RU; n++) begin
        tab_row[n] <= '0;
        tab_col[n] <= '0;
      end
    end else begin
      scan_done  <= 1'b0;
      sweep_done <= 1'b0;
      if (go_scan) begin
        // scan_start wins over a same-cycle recompute_req in ARMED
        state       <= SCAN;
        busy        <= 1'b1;
        idx         <= '0;
        scan_r      <= '0;
        scan_c      <= '0;
        overflow    <= 1'b0;
        fault_count <= '0;
        tab_vld     <= '0;
        for (int unsigned n = 0; n < NUM_RU; n++) begin
          tab_row[n] <= '0;
          tab_col[n] <= '0;
        end
      end else begin
        case (state)
          SCAN: begin
            if (!pe_pass) begin
              if (fault_count == FW'(NUM_RU)) begin
                overflow <= 1'b1;
              end else begin
                for (int unsigned n = 0; n < NUM_RU; n++) begin
                  if (FW'(n) == fault_count) begin
                    tab_row[n] <= scan_r;
                    tab_col[n] <= scan_c;
                    tab_vld[n] <= 1'b1;
                  end
                end
                fault_count <= fault_count + 1'b1;
              end
            end
            idx <= idx + 1'b1;
            if (scan_c == CW'(COLS - 1)) begin
              scan_c <= '0;
              scan_r <= scan_r + 1'b1;
            end else begin
              scan_c <= scan_c + 1'b1;
            end
            if (idx == IW'(ROWS * COLS - 1)) begin
              state     <= ARMED;
              busy      <= 1'b0;
              scan_done <= 1'b1;
            end
          end
          ARMED: begin
            if (recompute_req) begin
              if (fault_count != '0) begin
                state    <= SWEEP;
                busy     <= 1'b1;
                k        <= '0;
                ru_valid <= tab_vld;
                data_col <= '0;
                for (int unsigned n = 0; n < NUM_RU; n++) begin
                  data_row[n*RW +: RW]   <= tab_row[n];
                  weight_row[n*RW +: RW] <= tab_row[n];
                  weight_col[n*CW +: CW] <= tab_col[n];
                end
              end else begin
                sweep_done <= 1'b1;
              end
            end
          end
          SWEEP: begin
            if (!stall) begin
              if (k == CW'(COLS - 1)) begin
                state      <= ARMED;
                busy       <= 1'b0;
                sweep_done <= 1'b1;
                ru_valid   <= '0;
                data_row   <= '0;
                data_col   <= '0;
                weight_row <= '0;
                weight_col <= '0;
              end else begin
                k <= k + 1'b1;
                for (int unsigned n = 0; n < NUM_RU; n++) begin
                  data_col[n*CW +: CW] <= tab_vld[n] ? CW'(k + 1'b1) : '0;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
